// File: rtl/async_updowncount.sv
// async_updowncount: synchronous up/down counter with terminal count; define ASYNC_UPDOWNCOUNT_SAT_EN to saturate instead of wrap
module async_updowncount #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  logic             at_limit;
  logic [WIDTH-1:0] count_nxt;
  always_comb begin
    at_limit = up_down ? &count : ~|count;
    tc = !reset && at_limit;
`ifdef ASYNC_UPDOWNCOUNT_SAT_EN
    count_nxt = reset ? '0 : at_limit ? count : up_down ? count + 1'b1 : count - 1'b1;
`else
    count_nxt = reset ? '0 : up_down ? count + 1'b1 : count - 1'b1;
`endif
  end
  always_ff @(posedge clk) count <= count_nxt;
endmodule

// File: tb/tb_async_updowncount.sv
// tb_async_updowncount: directed scoreboard bench for async_updowncount
module tb_async_updowncount;
  localparam int W = 3;
  localparam logic [W-1:0] MAX = '1;
  logic clk = 1'b0, reset = 1'b1, up_down = 1'b1;
  logic [W-1:0] count, m, e;
  logic tc;
  logic [W-1:0] q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  async_updowncount #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .up_down(up_down),
    .count(count),
    .tc(tc)
  );
  task automatic step(input logic r, input logic ud);
    logic et;
    reset = r;
    up_down = ud;
    #1;
    et = !r && (ud ? (m == MAX) : (m == '0));
    checks++;
    assert (tc === et) else begin
      errors++;
      $error("FAIL tc obs=%b exp=%b (count=%0d reset=%b up_down=%b)", tc, et, count, r, ud);
    end
`ifdef ASYNC_UPDOWNCOUNT_SAT_EN
    m = r ? '0 : ud ? ((m == MAX) ? m : W'(m + 1)) : ((m == '0) ? m : W'(m - 1));
`else
    m = r ? '0 : ud ? W'(m + 1) : W'(m - 1);
`endif
    q.push_back(m);
    @(posedge clk);
    #1;
    e = q.pop_front();
    checks++;
    assert (count === e) else begin
      errors++;
      $error("FAIL count obs=%0d exp=%0d (reset=%b up_down=%b)", count, e, r, ud);
    end
  endtask
  initial begin
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, i[0] ? 1'b0 : 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, i[0]);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
